// File: rtl/ser_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// SER_RX_PARITY_EN appends an even-parity bit to every frame.
package ser_rx_pkg;

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 4;

`ifdef SER_RX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  localparam int unsigned FrameLen = DefDataW + ParBits;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + ParBits;
  endfunction

endpackage

// File: rtl/ser_rx_fifo_mem.sv
// Word FIFO: storage, pointers, occupancy and push/pop arbitration.
module ser_rx_fifo_mem
  import ser_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head,
  output logic [PTR_W:0]    level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    level_q;
  logic              pop_ok, push_ok;

  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves at the same edge.
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ser_word_rx.sv
// Serial-to-word receiver: MSB-first deserialiser feeding a word FIFO.
// Define SER_RX_PARITY_EN to check an even-parity bit after each word.
module ser_word_rx
  import ser_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              ser_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              err_clr,
  output logic              overflow,
  output logic              frame_err,
  output logic              par_err,
  output logic [PTR_W:0]    level
);

  localparam int unsigned FrameW = frame_len(DATA_W);
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameW - 1);

  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              overflow_q, frame_err_q;

  logic              last_bit, par_ok, push, full, empty, pop_fire;
  logic              ovf_evt, frame_evt;
  logic [DATA_W-1:0] push_data;

  assign last_bit  = ser_valid & ~ser_start & (state_q == SHIFT) & (bit_cnt_q == LastCnt);
  assign frame_evt = ser_valid & ser_start & (state_q == SHIFT);

`ifdef SER_RX_PARITY_EN
  logic par_err_q;
  // Data bits are already in shreg; the final bit only carries parity.
  assign push_data = shreg_q;
  assign par_ok    = ~(^shreg_q ^ ser_in);
  assign par_err   = par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= (last_bit & ~par_ok) | (par_err_q & ~err_clr);
    end
  end
`else
  assign push_data = {shreg_q[DATA_W-2:0], ser_in};
  assign par_ok    = 1'b1;
  assign par_err   = 1'b0;
`endif

  assign push     = last_bit & par_ok;
  assign pop_fire = rd_ready & ~empty;
  assign ovf_evt  = push & full & ~pop_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt | (overflow_q & ~err_clr);
      frame_err_q <= frame_evt | (frame_err_q & ~err_clr);
      if (ser_valid) begin
        if (ser_start) begin
          // A start bit always opens a fresh frame, abandoning any partial one.
          shreg_q   <= {{(DATA_W-1){1'b0}}, ser_in};
          bit_cnt_q <= CntW'(1);
          state_q   <= SHIFT;
        end else if (state_q == SHIFT) begin
          if (bit_cnt_q == LastCnt) begin
            bit_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            shreg_q   <= {shreg_q[DATA_W-2:0], ser_in};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  ser_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_ready),
    .full      (full),
    .empty     (empty),
    .head      (rd_data),
    .level     (level)
  );

  assign rd_valid  = ~empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ser_word_rx.sv
// Scoreboard bench for ser_word_rx: expected words queue on send, compare on read.
module tb_ser_word_rx;

`ifdef SER_RX_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0, ser_valid = 1'b0, ser_start = 1'b0;
  logic       rd_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, overflow, frame_err, par_err;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic exp_ovf = 1'b0, exp_ferr = 1'b0, exp_par = 1'b0;

  always #5 clk = ~clk;

  ser_word_rx dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_start (ser_start),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .err_clr   (err_clr),
    .overflow  (overflow),
    .frame_err (frame_err),
    .par_err   (par_err),
    .level     (level)
  );

  task automatic send_bit(input logic b, input logic s, input bit rdy);
    ser_in = b; ser_start = s; ser_valid = 1'b1;
    if (rdy) begin
      rd_ready = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL same_edge_pop: got %h, required a stored word", rd_data);
      end else begin
        if (rd_data !== exp_q[0]) begin
          errors++; $display("FAIL same_edge_pop: got %h required %h", rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk); #1;
    ser_valid = 1'b0; ser_start = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic check_status(input string tag);
    checks += 5;
    if (level !== 3'(exp_q.size())) begin
      errors++; $display("FAIL %s level: got %0d required %0d", tag, level, exp_q.size());
    end
    if (rd_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL %s rd_valid: got %b required %b", tag, rd_valid, exp_q.size() != 0);
    end
    if (overflow !== exp_ovf) begin
      errors++; $display("FAIL %s overflow: got %b required %b", tag, overflow, exp_ovf);
    end
    if (frame_err !== exp_ferr) begin
      errors++; $display("FAIL %s frame_err: got %b required %b", tag, frame_err, exp_ferr);
    end
    if (par_err !== exp_par) begin
      errors++; $display("FAIL %s par_err: got %b required %b", tag, par_err, exp_par);
    end
  endtask

  // Sends one frame; gap_len idle cycles are inserted before bit index gap_at.
  task automatic send_word(input logic [7:0] w, input int gap_at, input int gap_len,
                           input bit rdy_last, input bit bad_par);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
      send_bit(w[7-i], i == 0, rdy_last && (i == 7) && !Par);
    end
    if (Par) send_bit((^w) ^ bad_par, 1'b0, rdy_last);
    if (Par && bad_par) exp_par = 1'b1;
    else if (exp_q.size() < Depth) exp_q.push_back(w);
    else exp_ovf = 1'b1;
    check_status($sformatf("word_%h", w));
  endtask

  task automatic read_word(input string tag);
    int n = 0;
    while (!rd_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!rd_valid || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s read: rd_valid %b, required a word (queue %0d)", tag, rd_valid, exp_q.size());
    end else begin
      if (rd_data !== exp_q[0]) begin
        errors++; $display("FAIL %s read: got %h required %h", tag, rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_ovf = 1'b0; exp_ferr = 1'b0; exp_par = 1'b0;
    check_status("err_clr");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0; exp_ferr = 1'b0; exp_par = 1'b0;
    check_status("reset");
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL reset rd_data: got %h required 00", rd_data);
    end
  endtask

  task automatic test_single();
    send_word(8'hA5, -1, 0, 1'b0, 1'b0);
    read_word("single");
    check_status("single_pop");
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL single_pop rd_data: got %h required 00", rd_data);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] ws [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (ws[i]) send_word(ws[i], -1, 0, 1'b0, 1'b0);
    repeat (4) read_word("ovf_drain");
    check_status("ovf_empty");
    send_word(8'h66, -1, 0, 1'b0, 1'b0);
    send_word(8'h77, -1, 0, 1'b0, 1'b0);
    read_word("wrap");
    read_word("wrap");
    clear_errs();
  endtask

  task automatic test_gap();
    send_word(8'hC3, 4, 3, 1'b0, 1'b0);
    read_word("gap");
  endtask

  task automatic test_frame_err();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    exp_ferr = 1'b1;
    send_word(8'h5A, -1, 0, 1'b0, 1'b0);
    read_word("frame_err");
    clear_errs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ws [4] = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    foreach (ws[i]) send_word(ws[i], -1, 0, 1'b0, 1'b0);
    send_word(8'h99, -1, 0, 1'b1, 1'b0);
    repeat (4) read_word("same_edge");
    check_status("same_edge_empty");
  endtask

  task automatic test_reset_mid();
    send_word(8'h12, -1, 0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
    test_reset();
    send_word(8'h0F, -1, 0, 1'b0, 1'b0);
    read_word("post_reset");
  endtask

  task automatic test_parity();
    send_word(8'hA5, -1, 0, 1'b0, 1'b0);
    send_word(8'hA5, -1, 0, 1'b0, 1'b1);
    read_word("parity");
    clear_errs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_gap();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    if (Par) test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser_word_rx.md
Name: ser_word_rx

Overview:
- Receiving end of the team's 1-bit serial shift link.
- Takes the bit stream that leaves the serial shift pipeline and reassembles it MSB-first into DATA_W-bit words.
- Stores the words in a DEPTH-entry word FIFO. This is the write side of the four-word, 8-bit memory image used by the link benches.
- Presents the stored words to a downstream consumer over a valid/ready read port.

Parameters:
- DATA_W, 8, bits per word; also the frame length in bits.
- DEPTH, 4, number of FIFO entries; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ser_in  in  1  serial data bit.
- ser_valid  in  1  ser_in carries a bit this cycle.
- ser_start  in  1  qualified by ser_valid; this bit is the first (MSB) bit of a frame.
- rd_data  out  DATA_W  head FIFO word; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the head word.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- frame_err  out  1  sticky: a frame was restarted before it completed.
- par_err  out  1  sticky parity error; tied 0 unless SER_RX_PARITY_EN is defined.
- level  out  PTR_W+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE; bit_cnt=0; shift register 0.
  - wr_ptr=0, rd_ptr=0, level=0, rd_valid=0, rd_data=0.
  - overflow, frame_err and par_err go to 0.
  - FIFO storage is not reset.
  - Reset mid-frame discards the partial word and any stored words.
- FSM states IDLE and SHIFT:
  - IDLE with ser_valid & ser_start: shreg=ser_in, bit_cnt=1, go to SHIFT.
  - IDLE with ser_valid & !ser_start: bit ignored.
  - SHIFT with ser_valid & !ser_start: shreg={shreg[DATA_W-2:0],ser_in}, bit_cnt+1.
  - SHIFT with ser_valid & ser_start: frame_err<=1, partial word discarded, shreg=ser_in, bit_cnt=1, stay in SHIFT.
  - ser_valid=0: hold all serial state, whatever the state.
- Word complete (the DATA_W-th bit is accepted):
  - Word = {shreg[DATA_W-2:0],ser_in} is pushed at that same edge; go to IDLE with bit_cnt=0.
  - rd_valid is high the cycle after that edge.
  - Latency from the last bit's edge to rd_valid is 1 cycle.
- Push rule:
  - Accepted if level<DEPTH, or if a pop occurs at the same edge.
  - Otherwise the word is dropped and overflow<=1; level and wr_ptr are unchanged.
- Pop:
  - Occurs on rd_valid & rd_ready; rd_ptr+1.
  - rd_ready while empty has no effect.
- level update: push only +1; pop only -1; push and pop together, no change.
- Pointers wrap modulo DEPTH.
- rd_data is combinational from mem[rd_ptr] when level!=0, else 0.
- err_clr clears all sticky flags. A new error event in the same cycle wins: the flag is set.

Optional Feature:
- SER_RX_PARITY_EN defined:
  - Frame is DATA_W+1 bits; the final bit is even parity over the data bits.
  - Word completes on the parity bit.
  - On mismatch the word is not pushed and par_err<=1.
  - On match, the push rules above apply.
- SER_RX_PARITY_EN undefined: frame is DATA_W bits; par_err is constant 0.

Decomposition:
- Package ser_rx_pkg holds:
  - state typedef {IDLE, SHIFT};
  - default DATA_W and DEPTH constants;
  - a localparam for frame length (DATA_W, or DATA_W+1 with parity).
- One sub-module, ser_rx_fifo_mem:
  - holds storage, pointers, level and the push/pop arbitration;
  - its interface is push/push_data/pop/full/empty/head.
- The top module keeps the FSM, bit counter and error flags.

Test Plan:
- Send 0xA5 as bits 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles, first with ser_start -> rd_valid=1 one cycle after the 8th bit, rd_data=0xA5, level=1. Pop -> rd_valid=0, rd_data=0.
- Send 0x11,0x22,0x33,0x44,0x55 with rd_ready=0 -> level=4 and overflow=1 after the 5th word. Reads then return 0x11..0x44 in order, and pointers wrap correctly on a following 0x66/0x77 pair.
- Send 0xC3 with ser_valid low for 3 cycles between bits 4 and 5 -> rd_data=0xC3, no errors.
- Send 3 bits, then a new frame 0x5A with ser_start -> frame_err=1, only 0x5A stored. err_clr -> frame_err=0.
- FIFO full, rd_ready=1 held, complete 0x99 -> same-edge push+pop, level stays 4, overflow stays 0, 0x99 read last.
- Assert rst after 5 bits of a frame -> all outputs at reset values. A following 0x0F is received cleanly.
- With SER_RX_PARITY_EN: 0xA5 with parity 0 -> stored. 0xA5 with parity 1 -> dropped, par_err=1.
